// File: rtl/present_sbox_round_sequencer.sv
// -----------------------------------------------------------------------------
// present_sbox_round_sequencer
//
// Purpose:
//   Walks one STATE_W-bit PRESENT state/round-key pair through an external,
//   shared CHUNK_W-bit (two-nibble) sbox + keyAdd datapath, one chunk per
//   datapath evaluation, lowest chunk first. It then returns the assembled
//   word S(state) ^ key.
//
// Optional feature (compile-time macro PRESENT_SEQ_TEMPORAL_REDUNDANCY_EN):
//   When the macro is defined, each chunk is held for two cycles. The first
//   datapath result goes into a shadow register and the second is compared
//   against it. Any mismatch raises a sticky fault. A faulty word is returned
//   as all-zero with fault=1. When the macro is undefined, fault is tied to 0.
//
// Ports:
//   clock     in   1        rising-edge clock
//   reset     in   1        asynchronous active-low reset
//   in_valid  in   1        state/key pair offered
//   in_ready  out  1        idle, able to accept (IDLE only)
//   in_state  in   STATE_W  state word
//   in_key    in   STATE_W  round-key word
//   dp_state  out  CHUNK_W  chunk to datapath io_state (0 outside RUN)
//   dp_key    out  CHUNK_W  chunk to datapath io_key   (0 outside RUN)
//   dp_out    in   CHUNK_W  datapath io_out (combinational return)
//   out_valid out  1        result word available
//   out_ready in   1        consumer accepts result
//   out_data  out  STATE_W  result word
//   fault     out  1        redundancy mismatch for this word
//   busy      out  1        not IDLE
// -----------------------------------------------------------------------------
module present_sbox_round_sequencer #(
  parameter int STATE_W = 64,
  parameter int CHUNK_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [STATE_W-1:0] in_key,
  output logic [CHUNK_W-1:0] dp_state,
  output logic [CHUNK_W-1:0] dp_key,
  input  logic [CHUNK_W-1:0] dp_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               fault,
  output logic               busy
);

  localparam int N_CHUNKS = STATE_W / CHUNK_W;
  localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int REST_W   = STATE_W - CHUNK_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_fsm;
  logic [IDX_W-1:0]   r_idx;
  // Chunks not yet presented to the datapath (chunk 0 goes straight to dp_*).
  logic [REST_W-1:0]  r_state;
  logic [REST_W-1:0]  r_key;
  // Results of chunks 0..idx-1, shifted in from the top so that the final
  // chunk completes the word without any variable indexing.
  logic [REST_W-1:0]  r_result;
  logic [CHUNK_W-1:0] r_dp_state;
  logic [CHUNK_W-1:0] r_dp_key;
  logic [STATE_W-1:0] r_out_data;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_fault;

  logic               w_advance;   // this edge commits the current chunk
  logic               w_mismatch;  // second evaluation disagrees with shadow

`ifdef PRESENT_SEQ_TEMPORAL_REDUNDANCY_EN
  logic               r_phase;     // 0: first evaluation, 1: second
  logic [CHUNK_W-1:0] r_shadow;

  always_comb begin
    w_advance  = r_phase;
    w_mismatch = r_phase && (dp_out != r_shadow);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase  <= 1'b0;
      r_shadow <= '0;
    end else if (r_fsm == S_RUN) begin
      r_phase <= ~r_phase;
      if (!r_phase) r_shadow <= dp_out;
    end else begin
      r_phase <= 1'b0;
    end
  end

  assign fault = r_fault;
`else
  always_comb begin
    w_advance  = 1'b1;
    w_mismatch = 1'b0;
  end

  assign fault = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fsm       <= S_IDLE;
      r_idx       <= '0;
      r_state     <= '0;
      r_key       <= '0;
      r_result    <= '0;
      r_dp_state  <= '0;
      r_dp_key    <= '0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_fsm      <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_idx      <= '0;
            r_fault    <= 1'b0;
            r_result   <= '0;
            r_dp_state <= in_state[CHUNK_W-1:0];
            r_dp_key   <= in_key[CHUNK_W-1:0];
            r_state    <= in_state[STATE_W-1:CHUNK_W];
            r_key      <= in_key[STATE_W-1:CHUNK_W];
          end
        end

        S_RUN: begin
          if (w_advance) begin
            if (w_mismatch) r_fault <= 1'b1;
            r_result <= {dp_out, r_result[REST_W-1:CHUNK_W]};
            if (r_idx == IDX_LAST) begin
              r_fsm       <= S_DONE;
              r_out_valid <= 1'b1;
              r_dp_state  <= '0;
              r_dp_key    <= '0;
              // A faulty word is never released; the fault flag is sticky
              // across chunks, so fold in the last chunk's compare here.
              r_out_data  <= (r_fault || w_mismatch) ? '0 : {dp_out, r_result};
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_dp_state <= r_state[CHUNK_W-1:0];
              r_dp_key   <= r_key[CHUNK_W-1:0];
              r_state    <= r_state >> CHUNK_W;
              r_key      <= r_key >> CHUNK_W;
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_fsm       <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_fsm       <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign dp_state  = r_dp_state;
  assign dp_key    = r_dp_key;

endmodule

// File: tb/tb_present_sbox_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_present_sbox_round_sequencer
//
// Purpose:
//   Directed bench for present_sbox_round_sequencer. It models the external
//   two-nibble PRESENT sbox/keyAdd datapath and computes a full-word reference.
//   Expected words go into a scoreboard queue at handshake and are compared
//   when the sequencer releases them.
//   Latency is counted in clock edges, from the accepting edge up to and
//   including the edge that raises out_valid.
// -----------------------------------------------------------------------------
module tb_present_sbox_round_sequencer;

  localparam int STATE_W = 64;
  localparam int CHUNK_W = 8;
  localparam int N_CHUNKS = STATE_W / CHUNK_W;
`ifdef PRESENT_SEQ_TEMPORAL_REDUNDANCY_EN
  localparam int LAT = 2 * N_CHUNKS + 1;
`else
  localparam int LAT = N_CHUNKS + 1;
`endif

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic [STATE_W-1:0] in_key;
  logic [CHUNK_W-1:0] dp_state;
  logic [CHUNK_W-1:0] dp_key;
  logic [CHUNK_W-1:0] dp_out;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;
  logic               fault;
  logic               busy;

  present_sbox_round_sequencer #(
    .STATE_W(STATE_W),
    .CHUNK_W(CHUNK_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_state (in_state),
    .in_key   (in_key),
    .dp_state (dp_state),
    .dp_key   (dp_key),
    .dp_out   (dp_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .fault    (fault),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [STATE_W-1:0] ref_layer(input logic [STATE_W-1:0] s,
                                                   input logic [STATE_W-1:0] k);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int i = 0; i < STATE_W / 4; i++)
      r[i*4 +: 4] = sbox(s[i*4 +: 4]) ^ k[i*4 +: 4];
    return r;
  endfunction

  // External combinational datapath, with an optional single-bit upset.
  logic inj;
  assign dp_out = {sbox(dp_state[7:4]) ^ dp_key[7:4],
                   sbox(dp_state[3:0]) ^ dp_key[3:0]} ^ {7'b0, inj};

  typedef struct packed {
    logic [STATE_W-1:0] data;
    logic               flt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;   // edges since (and including) the last accepting edge
  int   inj_edge = -1;  // edges value during which dp_out is corrupted

  assign inj = (inj_edge >= 0) && (edges == inj_edge) && busy;

  task automatic tick();
    @(posedge clock);
    #1;
    edges++;
  endtask

  task automatic chk(input string tag, input logic [STATE_W-1:0] obs,
                     input logic [STATE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a word; push its expected result when the handshake edge occurs.
  task automatic start(input logic [STATE_W-1:0] s, input logic [STATE_W-1:0] k,
                       input logic [STATE_W-1:0] exp_data, input logic exp_flt);
    int guard;
    exp_t e;
    guard = 0;
    while (!in_ready && guard < 200) begin tick(); guard++; end
    chk("in_ready_before_accept", {63'b0, in_ready}, 64'd1);
    in_state = s;
    in_key   = k;
    in_valid = 1'b1;
    e.data = exp_data;
    e.flt  = exp_flt;
    sb.push_back(e);
    tick();
    edges    = 1;
    in_valid = 1'b0;
    chk("busy_after_accept", {63'b0, busy}, 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    while (!out_valid && edges < 200) tick();
    chk(tag, 64'(edges), 64'(LAT));
  endtask

  task automatic receive(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"},  out_data,           e.data);
      chk({tag, "_fault"}, {63'b0, fault},     {63'b0, e.flt});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_in_ready"},  {63'b0, in_ready},  64'd1);
    chk({tag, "_idle_out_valid"}, {63'b0, out_valid}, 64'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"},  {63'b0, in_ready},  64'd1);
    chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_out_data"},  out_data,           64'd0);
    chk({tag, "_fault"},     {63'b0, fault},     64'd0);
    chk({tag, "_busy"},      {63'b0, busy},      64'd0);
    chk({tag, "_dp"},        {48'b0, dp_state, dp_key}, 64'd0);
  endtask

  initial begin
    logic [STATE_W-1:0] held;
    logic [STATE_W-1:0] rs;
    logic [STATE_W-1:0] rk;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_key    = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk_reset_values("reset");
    reset = 1'b1;
    tick();

    // 1: all-zero state and key.
    start(64'h0, 64'h0, 64'hCCCC_CCCC_CCCC_CCCC, 1'b0);
    wait_valid("lat_zero");
    receive("zero");

    // 2: counting nibbles, zero key.
    start(64'h0123456789ABCDEF, 64'h0, 64'hC56B90AD3EF84712, 1'b0);
    wait_valid("lat_count");
    receive("count");

    // 3: counting nibbles, all-ones key.
    start(64'h0123456789ABCDEF, '1, 64'h3A946F52C107B8ED, 1'b0);
    wait_valid("lat_ones");
    receive("ones");

    // 4: in_valid pulsed mid-RUN is ignored; out_data holds while out_ready is low.
    start(64'hFEDCBA9876543210, 64'h0F0F_00FF_1234_5678,
          ref_layer(64'hFEDCBA9876543210, 64'h0F0F_00FF_1234_5678), 1'b0);
    tick();
    in_state = 64'hDEAD_BEEF_DEAD_BEEF;
    in_valid = 1'b1;
    chk("run_in_ready_low", {63'b0, in_ready}, 64'd0);
    tick();
    in_valid = 1'b0;
    wait_valid("lat_hold");
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out_data",  out_data,           held);
      chk("hold_out_valid", {63'b0, out_valid}, 64'd1);
      chk("hold_in_ready",  {63'b0, in_ready},  64'd0);
    end
    receive("hold");
    repeat (3) tick();
    chk("no_queued_word_valid", {63'b0, out_valid}, 64'd0);
    chk("no_queued_word_busy",  {63'b0, busy},      64'd0);

    // 5: asynchronous reset at chunk 4 discards the word.
    start(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, '0, 1'b0);
    repeat (4) tick();
    #2;
    reset = 1'b0;
    #1;
    chk_reset_values("midrun_reset");
    void'(sb.pop_back());
    tick();
    reset = 1'b1;
    tick();
    start(64'h0123456789ABCDEF, 64'h0, 64'hC56B90AD3EF84712, 1'b0);
    wait_valid("lat_after_reset");
    receive("after_reset");

    // Random words, with the expected values taken from the reference layer.
    for (int n = 0; n < 4; n++) begin
      rs = {$urandom(), $urandom()};
      rk = {$urandom(), $urandom()};
      start(rs, rk, ref_layer(rs, rk), 1'b0);
      wait_valid("lat_rand");
      receive("rand");
    end

`ifdef PRESENT_SEQ_TEMPORAL_REDUNDANCY_EN
    // 6: upset on the second evaluation of chunk 3, then a clean word.
    inj_edge = 2 * 3 + 2;
    start(64'h0123456789ABCDEF, 64'h0, 64'h0, 1'b1);
    wait_valid("lat_fault");
    chk("fault_flag_done", {63'b0, fault}, 64'd1);
    receive("fault");
    inj_edge = -1;
    start(64'h0123456789ABCDEF, '1, 64'h3A946F52C107B8ED, 1'b0);
    wait_valid("lat_clean");
    receive("clean");
`endif

    chk("sb_empty_at_end", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
